// File: rtl/uart_cfg.sv
`default_nettype none
// uart_cfg: 16x-oversampled UART with runtime divisor, optional parity, sticky errors
// and byte FIFOs on both directions. Revision 1.0.

module uart_cfg_fifo #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         wr_i,
  input  logic [7:0]   wdata_i,
  input  logic         rd_i,
  output logic [7:0]   rdata_o,
  output logic         empty_o,
  output logic         full_o,
  output logic [W:0]   level_o
);
  localparam int DEPTH = 1 << W;

  logic [7:0]   mem_q [DEPTH];
  logic [W-1:0] wr_ptr_q, rd_ptr_q;
  logic [W:0]   level_q, level_d;
  logic         empty_q, full_q;
  logic         do_wr, do_rd;

  // A write into a full FIFO still lands when a read frees a slot in the same clk.
  always_comb begin
    do_rd   = rd_i & ~empty_q;
    do_wr   = wr_i & (~full_q | do_rd);
    level_d = level_q;
    if (do_wr && !do_rd) begin
      level_d = level_q + (W+1)'(1);
    end else if (do_rd && !do_wr) begin
      level_d = level_q - (W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + W'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + W'(1);
      end
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == (W+1)'(DEPTH));
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign level_o = level_q;
endmodule

module uart_cfg #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR_BIT = 16,
  parameter int FIFO_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic                par_en,
  input  logic                par_odd,
  input  logic                rd_uart,
  input  logic                wr_uart,
  input  logic [7:0]          w_data,
  input  logic                clr_err,
  input  logic                rx,
  output logic                tx,
  output logic [7:0]          r_data,
  output logic                rx_empty,
  output logic                tx_full,
  output logic [FIFO_W:0]     rx_level,
  output logic [FIFO_W:0]     tx_level,
  output logic [2:0]          err
);
  localparam logic [7:0] DMASK   = 8'((1 << DBIT) - 1);
  localparam logic [5:0] STOP_LS = 6'(SB_TICK - 1);
  localparam logic [2:0] LAST_N  = 3'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // ---------------- baud tick ----------------
  logic [DVSR_BIT-1:0] baud_q, baud_d, baud_top;
  logic                tick;

  always_comb begin
    baud_top = (dvsr == '0) ? '0 : dvsr - DVSR_BIT'(1);
    tick     = (baud_q == baud_top);
    baud_d   = (baud_q >= baud_top) ? '0 : baud_q + DVSR_BIT'(1);
  end

  // ---------------- rx synchroniser ----------------
  logic [1:0] rx_sync_q;
  logic       rx_s;
  assign rx_s = rx_sync_q[1];

  // ---------------- FIFOs ----------------
  logic [7:0] tx_head;
  logic       tx_empty, tx_pop;
  logic       rx_full;
  logic [7:0] rx_b_q, rx_b_d;
  logic       rx_push_q, rx_push_d;

  uart_cfg_fifo #(.W(FIFO_W)) u_tx_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .wr_i    (wr_uart),
    .wdata_i (w_data & DMASK),
    .rd_i    (tx_pop),
    .rdata_o (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .level_o (tx_level)
  );

  uart_cfg_fifo #(.W(FIFO_W)) u_rx_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .wr_i    (rx_push_q),
    .wdata_i (rx_b_q),
    .rd_i    (rd_uart),
    .rdata_o (r_data),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .level_o (rx_level)
  );

  // ---------------- receiver ----------------
  uart_state_e rx_st_q, rx_st_d;
  logic [5:0]  rx_s_q, rx_s_d;
  logic [2:0]  rx_n_q, rx_n_d;
  logic        ev_par, ev_frm, ev_ovr;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_s_d    = rx_s_q;
    rx_n_d    = rx_n_q;
    rx_b_d    = rx_b_q;
    rx_push_d = 1'b0;
    ev_par    = 1'b0;
    ev_frm    = 1'b0;
    case (rx_st_q)
      ST_IDLE: begin
        if (!rx_s) begin
          rx_st_d = ST_START;
          rx_s_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_s_q == 6'd7) begin
            rx_s_d  = '0;
            rx_n_d  = '0;
            rx_st_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_s_d = rx_s_q + 6'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (rx_s_q == 6'd15) begin
            rx_s_d         = '0;
            rx_b_d[rx_n_q] = rx_s;
            if (rx_n_q == LAST_N) begin
              rx_st_d = par_en ? ST_PAR : ST_STOP;
            end else begin
              rx_n_d = rx_n_q + 3'd1;
            end
          end else begin
            rx_s_d = rx_s_q + 6'd1;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          if (rx_s_q == 6'd15) begin
            rx_s_d  = '0;
            ev_par  = (rx_s != ((^rx_b_q) ^ par_odd));
            rx_st_d = ST_STOP;
          end else begin
            rx_s_d = rx_s_q + 6'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rx_s_q == STOP_LS) begin
            ev_frm    = ~rx_s;
            rx_push_d = 1'b1;
            rx_st_d   = ST_IDLE;
          end else begin
            rx_s_d = rx_s_q + 6'd1;
          end
        end
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  // A full RX FIFO only accepts the word if the host pops in the same clk.
  assign ev_ovr = rx_push_q & rx_full & ~rd_uart;

  // ---------------- transmitter ----------------
  uart_state_e tx_st_q, tx_st_d;
  logic [5:0]  tx_s_q, tx_s_d;
  logic [2:0]  tx_n_q, tx_n_d;
  logic [7:0]  tx_b_q, tx_b_d;
  logic        tx_par_q, tx_par_d;
  logic        tx_q, tx_d;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_s_d   = tx_s_q;
    tx_n_d   = tx_n_q;
    tx_b_d   = tx_b_q;
    tx_par_d = tx_par_q;
    tx_d     = tx_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_b_d   = tx_head;
          tx_par_d = ^tx_head;
          tx_pop   = 1'b1;
          tx_d     = 1'b0;
          tx_s_d   = '0;
          tx_st_d  = ST_START;
        end
      end
      // The first tick after the falling edge is only a phase reference; 16 more follow.
      ST_START: begin
        if (tick) begin
          if (tx_s_q == 6'd16) begin
            tx_s_d  = '0;
            tx_n_d  = '0;
            tx_d    = tx_b_q[0];
            tx_st_d = ST_DATA;
          end else begin
            tx_s_d = tx_s_q + 6'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_s_q == 6'd15) begin
            tx_s_d = '0;
            if (tx_n_q == LAST_N) begin
              if (par_en) begin
                tx_d    = tx_par_q ^ par_odd;
                tx_st_d = ST_PAR;
              end else begin
                tx_d    = 1'b1;
                tx_st_d = ST_STOP;
              end
            end else begin
              tx_n_d = tx_n_q + 3'd1;
              tx_b_d = tx_b_q >> 1;
              tx_d   = tx_b_q[1];
            end
          end else begin
            tx_s_d = tx_s_q + 6'd1;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          if (tx_s_q == 6'd15) begin
            tx_s_d  = '0;
            tx_d    = 1'b1;
            tx_st_d = ST_STOP;
          end else begin
            tx_s_d = tx_s_q + 6'd1;
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (tx_s_q == STOP_LS) begin
            tx_s_d  = '0;
            tx_st_d = ST_IDLE;
          end else begin
            tx_s_d = tx_s_q + 6'd1;
          end
        end
      end
      default: tx_st_d = ST_IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  logic [2:0] err_q, err_d;
  assign err_d = (err_q & {3{~clr_err}}) | {ev_ovr, ev_frm, ev_par};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q    <= '0;
      rx_sync_q <= 2'b11;
      rx_st_q   <= ST_IDLE;
      rx_s_q    <= '0;
      rx_n_q    <= '0;
      rx_b_q    <= '0;
      rx_push_q <= 1'b0;
      tx_st_q   <= ST_IDLE;
      tx_s_q    <= '0;
      tx_n_q    <= '0;
      tx_b_q    <= '0;
      tx_par_q  <= 1'b0;
      tx_q      <= 1'b1;
      err_q     <= '0;
    end else begin
      baud_q    <= baud_d;
      rx_sync_q <= {rx_sync_q[0], rx};
      rx_st_q   <= rx_st_d;
      rx_s_q    <= rx_s_d;
      rx_n_q    <= rx_n_d;
      rx_b_q    <= rx_b_d;
      rx_push_q <= rx_push_d;
      tx_st_q   <= tx_st_d;
      tx_s_q    <= tx_s_d;
      tx_n_q    <= tx_n_d;
      tx_b_q    <= tx_b_d;
      tx_par_q  <= tx_par_d;
      tx_q      <= tx_d;
      err_q     <= err_d;
    end
  end

  assign tx  = tx_q;
  assign err = err_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_cfg.sv
`timescale 1ns/1ps
// tb_uart_cfg: self-checking bench for uart_cfg (table vectors, loopback, random traffic).
module tb_uart_cfg;
  localparam int DBIT = 8, SB_TICK = 16, DVSR_BIT = 16, FIFO_W = 2;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic [DVSR_BIT-1:0] dvsr = 16'd4;
  logic                par_en = 1'b0, par_odd = 1'b0;
  logic                rd_uart = 1'b0, wr_uart = 1'b0, clr_err = 1'b0;
  logic [7:0]          w_data = '0;
  logic                loop_en = 1'b0, rx_drv = 1'b1;
  logic                rx_line, tx;
  logic [7:0]          r_data;
  logic                rx_empty, tx_full;
  logic [FIFO_W:0]     rx_level, tx_level;
  logic [2:0]          err;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_cfg #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR_BIT(DVSR_BIT), .FIFO_W(FIFO_W)) dut (
    .clk(clk), .reset(reset_n), .dvsr(dvsr), .par_en(par_en), .par_odd(par_odd),
    .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .clr_err(clr_err),
    .rx(rx_line), .tx(tx), .r_data(r_data), .rx_empty(rx_empty), .tx_full(tx_full),
    .rx_level(rx_level), .tx_level(tx_level), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  bit seen;

  typedef struct {
    logic [7:0] data;
    bit         pen;
    bit         dut_odd;
    bit         pbit;
    bit         stop;
    logic [7:0] exp_rdata;
    logic [2:0] exp_err;
  } rx_vec_t;
  rx_vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk); rd_uart = 1'b1;
    @(negedge clk); rd_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  // Bench-side serial transmitter; a zero stop bit is held only long enough to be sampled.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input bit stop, input int dv);
    int bt;
    bt = 16 * dv;
    rx_drv = 1'b0; tick_n(bt);
    for (int i = 0; i < DBIT; i++) begin
      rx_drv = d[i]; tick_n(bt);
    end
    if (pen) begin
      rx_drv = pbit; tick_n(bt);
    end
    if (stop) begin
      rx_drv = 1'b1; tick_n(bt);
    end else begin
      rx_drv = 1'b0; tick_n(12 * dv);
    end
    rx_drv = 1'b1; tick_n(8 * dv);
  endtask

  task automatic wait_rx(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!rx_empty) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic recv_all(input int n, input int budget, input string nm);
    int got, c;
    logic [7:0] e;
    got = 0; c = 0;
    while (got < n && c < budget) begin
      if (!rx_empty) begin
        e = exp_q.pop_front();
        chk(nm, r_data, e);
        got++;
        pop();
        c += 2;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    chk({nm, "_count"}, got, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [7:0] d;
    bit b, exp_b;
    int n, dv, dvm;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 3'b001};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 3'b010};
    tbl[2] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 3'b000};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 3'b000};
    tbl[4] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 3'b011};
    tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 3'b000};

    // ---- reset ----
    #2 reset_n = 1'b0;
    tick_n(3);
    @(negedge clk); reset_n = 1'b1;
    tick_n(2);
    chk("rst_tx", tx, 1);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_err", err, 0);
    chk("rst_r_data", r_data, 0);

    // ---- 0xA5 loopback, even parity, dvsr=4 ----
    loop_en = 1'b1; dvsr = 16'd4; par_en = 1'b1; par_odd = 1'b0;
    d = 8'hA5;
    @(negedge clk); wr_uart = 1'b1; w_data = d;
    @(negedge clk); wr_uart = 1'b0;
    chk("a5_level_after_wr", tx_level, 1);
    chk("a5_tx_before_fall", tx, 1);
    @(negedge clk);
    chk("a5_tx_fall", tx, 0);
    chk("a5_level_after_pop", tx_level, 0);
    tick_n(32);
    for (int k = 0; k < 11; k++) begin
      if (k == 0) exp_b = 1'b0;
      else if (k <= 8) exp_b = d[k-1];
      else if (k == 9) exp_b = (^d) ^ 1'b0;
      else exp_b = 1'b1;
      b = tx;
      chk($sformatf("a5_txbit%0d", k), b, exp_b);
      tick_n(64);
    end
    wait_rx(800, ok);
    chk("a5_rx_arrived", ok, 1);
    chk("a5_r_data", r_data, 8'hA5);
    chk("a5_err", err, 0);
    pop();
    chk("a5_rx_empty_after_pop", rx_empty, 1);

    // ---- parity error while clr_err is held: the event still sets err[0] for one clk ----
    loop_en = 1'b0; par_en = 1'b1; par_odd = 1'b1;
    tick_n(64);
    clr_err = 1'b1; seen = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 4);
      begin
        for (int i = 0; i < 900; i++) begin
          @(negedge clk);
          if (err[0]) seen = 1'b1;
        end
      end
    join
    clr_err = 1'b0;
    chk("clr_vs_event_seen", seen, 1);
    chk("clr_held_err", err, 0);
    chk("clr_rx_empty", rx_empty, 0);
    chk("clr_r_data", r_data, 8'hA5);
    pop();

    // ---- table-driven received frames ----
    for (int i = 0; i < 6; i++) begin
      par_en = tbl[i].pen; par_odd = tbl[i].dut_odd;
      pulse_clr();
      send_frame(tbl[i].data, tbl[i].pen, tbl[i].pbit, tbl[i].stop, 4);
      wait_rx(400, ok);
      chk($sformatf("tbl%0d_arrived", i), ok, 1);
      chk($sformatf("tbl%0d_r_data", i), r_data, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      pop();
      chk($sformatf("tbl%0d_empty", i), rx_empty, 1);
      pulse_clr();
      chk($sformatf("tbl%0d_err_cleared", i), err, 0);
    end

    // ---- 3-clk glitch on rx, then a normal frame ----
    par_en = 1'b0; par_odd = 1'b0;
    @(negedge clk); rx_drv = 1'b0;
    tick_n(3); rx_drv = 1'b1;
    tick_n(200);
    chk("glitch_no_push", rx_empty, 1);
    chk("glitch_err", err, 0);
    send_frame(8'h69, 1'b0, 1'b0, 1'b1, 4);
    wait_rx(400, ok);
    chk("glitch_next_arrived", ok, 1);
    chk("glitch_next_r_data", r_data, 8'h69);
    pop();

    // ---- six back-to-back writes: one in flight, four queued, one dropped ----
    loop_en = 1'b1; dvsr = 16'd2; par_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_uart = 1'b1;
      w_data = 8'($urandom_range(0, 255));
      if (i < 5) exp_q.push_back(w_data);
    end
    @(negedge clk); wr_uart = 1'b0;
    chk("burst_tx_full", tx_full, 1);
    chk("burst_tx_level", tx_level, 4);
    recv_all(5, 2600, "burst_rx");
    tick_n(800);
    chk("burst_no_sixth", rx_empty, 1);
    chk("burst_tx_drained", tx_level, 0);
    chk("burst_tx_full_clear", tx_full, 0);
    chk("burst_err", err, 0);

    // ---- randomized loopback against a byte queue ----
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(0, 5);
      dvm = (dv == 0) ? 1 : dv;
      dvsr = DVSR_BIT'(dv);
      par_en = 1'($urandom_range(0, 1));
      par_odd = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 5);
      exp_q.delete();
      tick_n(40 * dvm);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        wr_uart = 1'b1;
        w_data = 8'($urandom_range(0, 255));
        exp_q.push_back(w_data);
      end
      @(negedge clk); wr_uart = 1'b0;
      recv_all(n, n * (200 * dvm + 20) + 300, $sformatf("rand%0d", it));
      chk($sformatf("rand%0d_err", it), err, 0);
      tick_n(32 * dvm);
    end

    // ---- overrun: five frames, no reads ----
    loop_en = 1'b0; dvsr = 16'd4; par_en = 1'b0; par_odd = 1'b0;
    tick_n(100);
    pulse_clr();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 4) exp_q.push_back(d);
      send_frame(d, 1'b0, 1'b0, 1'b1, 4);
    end
    tick_n(20);
    chk("ovr_rx_level", rx_level, 4);
    chk("ovr_err", err, 3'b100);
    recv_all(3, 40, "ovr_rx");
    chk("ovr_rx_level_left", rx_level, 1);
    chk("ovr_err_sticky", err, 3'b100);

    // ---- asynchronous reset in the middle of a TX frame ----
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); wr_uart = 1'b1; w_data = 8'h55 + 8'(i);
    end
    @(negedge clk); wr_uart = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rstmid_tx_started", ok, 1);
    tick_n(100);
    chk("rstmid_queued", tx_level, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_tx", tx, 1);
    chk("rstmid_tx_level", tx_level, 0);
    chk("rstmid_rx_level", rx_level, 0);
    chk("rstmid_err", err, 0);
    chk("rstmid_rx_empty", rx_empty, 1);
    chk("rstmid_r_data", r_data, 0);
    tick_n(2);
    reset_n = 1'b1;
    tick_n(50);
    chk("rstmid_idle_tx", tx, 1);
    chk("rstmid_idle_level", tx_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
